// File: rtl/uart_tx_sched.sv
// ICB master: configures the UART after reset, then round-robin shares its TX
// data register among NREQ byte requesters, polling tx_ok before each write.
module uart_tx_sched #(
  parameter int unsigned     NREQ      = 2,
  parameter int unsigned     PA_W      = 32,
  parameter logic [PA_W-1:0] CSR_ADDR  = PA_W'(32'h1001_3004),
  parameter logic [PA_W-1:0] CTRL_ADDR = PA_W'(32'h1001_3008),
  parameter logic [PA_W-1:0] DATA_ADDR = PA_W'(32'h1001_3000),
  parameter logic [31:0]     CSR_INIT  = 32'h0000_0100,
  parameter logic [31:0]     CTRL_INIT = 32'h0000_0111,
  parameter int unsigned     HOLDOFF   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [NREQ-1:0]   req_valid,
  input  logic [8*NREQ-1:0] req_data,
  output logic [NREQ-1:0]   req_ready,
  output logic              o_icb_cmd_valid,
  input  logic              o_icb_cmd_ready,
  output logic [PA_W-1:0]   o_icb_cmd_addr,
  output logic              o_icb_cmd_read,
  output logic [31:0]       o_icb_cmd_wdata,
  input  logic              o_icb_rsp_valid,
  output logic              o_icb_rsp_ready,
  input  logic [31:0]       o_icb_rsp_rdata,
  output logic              init_done,
  output logic              busy
);

  localparam int unsigned IW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned HW = $clog2(HOLDOFF + 1);

  typedef enum logic [2:0] {S_CFG_CSR, S_CFG_CTRL, S_IDLE, S_POLL, S_WRITE} state_e;

  state_e        state_q, state_d;
  logic          cmd_valid_q, cmd_valid_d;
  logic          wait_rsp_q, wait_rsp_d;
  logic          init_done_q, init_done_d;
  logic [IW-1:0] rr_q, rr_d, idx_q, idx_d;
  logic [7:0]    byte_q, byte_d;
  logic [HW-1:0] hold_q, hold_d;

  logic          grant_vld;
  logic [IW-1:0] grant_idx;
  logic [7:0]    grant_byte;
  logic          rdata_unused;

  assign rdata_unused = ^o_icb_rsp_rdata[31:1];

  // Round-robin: lowest valid index above the pointer, else lowest valid overall.
  always_comb begin
    grant_vld  = 1'b0;
    grant_idx  = '0;
    grant_byte = '0;
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!grant_vld && req_valid[i] && (i > 32'(rr_q))) begin
        grant_vld  = 1'b1;
        grant_idx  = IW'(i);
        grant_byte = req_data[8*i +: 8];
      end
    end
    for (int unsigned i = 0; i < NREQ; i++) begin
      if (!grant_vld && req_valid[i]) begin
        grant_vld  = 1'b1;
        grant_idx  = IW'(i);
        grant_byte = req_data[8*i +: 8];
      end
    end
  end

  always_comb begin
    state_d         = state_q;
    cmd_valid_d     = cmd_valid_q;
    wait_rsp_d      = wait_rsp_q;
    init_done_d     = init_done_q;
    rr_d            = rr_q;
    idx_d           = idx_q;
    byte_d          = byte_q;
    hold_d          = hold_q;
    req_ready       = '0;
    o_icb_cmd_addr  = '0;
    o_icb_cmd_read  = 1'b0;
    o_icb_cmd_wdata = '0;

    case (state_q)
      S_CFG_CSR: begin
        o_icb_cmd_addr  = CSR_ADDR;
        o_icb_cmd_wdata = CSR_INIT;
      end
      S_CFG_CTRL: begin
        o_icb_cmd_addr  = CTRL_ADDR;
        o_icb_cmd_wdata = CTRL_INIT;
      end
      S_POLL: begin
        o_icb_cmd_addr = CSR_ADDR;
        o_icb_cmd_read = 1'b1;
      end
      S_WRITE: begin
        o_icb_cmd_addr  = DATA_ADDR;
        o_icb_cmd_wdata = {24'h0, byte_q};
      end
      default: ;
    endcase

    if (state_q == S_IDLE) begin
      if (hold_q != '0) begin
        hold_d = hold_q - 1'b1;
      end else if (grant_vld) begin
        idx_d       = grant_idx;
        byte_d      = grant_byte;
        state_d     = S_POLL;
        cmd_valid_d = 1'b1;
      end
    end else if (!cmd_valid_q && !wait_rsp_q) begin
      // Only reached on the first cycle after reset.
      cmd_valid_d = 1'b1;
    end else if (cmd_valid_q && o_icb_cmd_ready) begin
      cmd_valid_d = 1'b0;
      wait_rsp_d  = 1'b1;
    end else if (wait_rsp_q && o_icb_rsp_valid) begin
      wait_rsp_d = 1'b0;
      case (state_q)
        S_CFG_CSR: begin
          state_d     = S_CFG_CTRL;
          cmd_valid_d = 1'b1;
        end
        S_CFG_CTRL: begin
          state_d     = S_IDLE;
          init_done_d = 1'b1;
        end
        S_POLL: begin
          if (o_icb_rsp_rdata[0]) state_d = S_WRITE;
          cmd_valid_d = 1'b1;
        end
        S_WRITE: begin
          for (int unsigned i = 0; i < NREQ; i++) req_ready[i] = (idx_q == IW'(i));
          rr_d    = idx_q;
          hold_d  = HW'(HOLDOFF);
          state_d = S_IDLE;
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_CFG_CSR;
      cmd_valid_q <= 1'b0;
      wait_rsp_q  <= 1'b0;
      init_done_q <= 1'b0;
      rr_q        <= IW'(NREQ - 1);
      idx_q       <= '0;
      byte_q      <= '0;
      hold_q      <= '0;
    end else begin
      state_q     <= state_d;
      cmd_valid_q <= cmd_valid_d;
      wait_rsp_q  <= wait_rsp_d;
      init_done_q <= init_done_d;
      rr_q        <= rr_d;
      idx_q       <= idx_d;
      byte_q      <= byte_d;
      hold_q      <= hold_d;
    end
  end

  assign o_icb_cmd_valid = cmd_valid_q;
  assign o_icb_rsp_ready = 1'b1;
  assign init_done       = init_done_q;
  assign busy            = (state_q != S_IDLE);

endmodule
